vx_gbar_unit: RTL and testbench
===============================

// Module: vx_gbar_unit
// PURPOSE
//  Cluster-level global barrier unit, downstream of each core's gbar_bus_if master.
//  Collects barrier-arrival requests from NUM_CORES cores and tracks per-barrier arrival masks.
//  When the expected number of cores has arrived, broadcasts a one-cycle release to all cores.
//  One request is accepted per cycle, chosen by a round-robin arbiter.
// PARAMETERS
//  NUM_CORES     4   cores attached; power of two, >=2
//  NUM_BARRIERS  16  barrier ids tracked; power of two
//  BAR_ID_W      clog2(NUM_BARRIERS)  derived; barrier id width
//  CORE_W        clog2(NUM_CORES)     derived; core index and size_m1 width
// PORTS
//  clk          in   1                  clock
//  reset        in   1                  async, active-high
//  req_valid    in   NUM_CORES          core i has an arrival pending
//  req_id       in   NUM_CORES*BAR_ID_W barrier id, core i at slice [i*BAR_ID_W +: BAR_ID_W]
//  req_size_m1  in   NUM_CORES*CORE_W   participating cores minus 1, core i at slice i
//  req_ready    out  NUM_CORES          grant; the request fires on valid&ready
//  rsp_valid    out  1                  release pulse, broadcast to all cores, no backpressure
//  rsp_id       out  BAR_ID_W           barrier id being released
//  rsp_mask     out  NUM_CORES          cores that arrived at the released barrier
//  busy         out  1                  any barrier mask non-zero, or rsp_valid high
// BEHAVIOUR
//  Reset (async, any cycle):
//   - all arrival masks cleared; RR pointer = 0.
//   - rsp_valid=0, rsp_id=0, rsp_mask=0, busy=0.
//   - A release in flight is dropped.
//  Arbiter:
//   - req_ready is one-hot or zero, combinational from req_valid and the RR pointer.
//   - Search starts at the pointer. After a fire on core g, pointer <= (g+1) mod NUM_CORES; with no fire the pointer holds.
//   - A valid request must hold its id and size_m1 until it fires.
//  Accept at cycle N, core g, id b, size s:
//   - new_mask = mask[b] | (1<<g).
//   - Duplicate (mask[b][g] already set): no state change, request consumed, no release.
//   - popcount(new_mask) == s+1: release. Cycle N+1: rsp_valid=1, rsp_id=b, rsp_mask=new_mask. mask[b] <= 0 at the same edge.
//   - Otherwise: mask[b] <= new_mask, no rsp.
//  Size field:
//   - The size of the completing request decides release; earlier arrivals' sizes are not stored.
//   - size_m1=0: immediate self-release, latency 1.
//  Release timing:
//   - rsp_valid is a single-cycle pulse. Latency is exactly 1 cycle from the completing fire.
//   - Back-to-back releases on consecutive cycles are legal: rsp is registered every cycle.
//  Simultaneous events:
//   - A fire to barrier b in the cycle right after b released starts a fresh mask.
//   - Requests to different ids from different cores serialize via RR, one per cycle.
//  Storage:
//   - NUM_BARRIERS x NUM_CORES flop array.
//   - Popcount is combinational over CORE_W+1 bits; compare s+1 in CORE_W+1 bits (no wrap).
//  busy = |(OR of all masks) | rsp_valid; registered-state derived, no combinational input path.
// TESTING
//  1) Single barrier:
//     - Stimulus: cores 0..3 request id 5, size_m1 3, in successive cycles.
//     - Response: one rsp_valid the cycle after core 3 fires; rsp_id=5, rsp_mask=4'b1111; busy drops afterwards.
//  2) Round-robin:
//     - Stimulus: all 4 cores valid on id 2 in the same cycle, pointer=0.
//     - Response: grants in order 0,1,2,3 on 4 consecutive cycles; release the cycle after grant 3.
//  3) Duplicate arrival:
//     - Stimulus: core 1 hits id 7 twice, size_m1 1.
//     - Response: no release and mask stays 4'b0010; core 0 then fires and release follows with rsp_mask=4'b0011.
//  4) Interleaved ids:
//     - Stimulus: cores 0,1 on id 3 and cores 2,3 on id 9, all size_m1 1.
//     - Response: two independent releases (id 3 mask 0011, id 9 mask 1100), each exactly 1 cycle after its completing fire.
//  5) Self-release and reuse:
//     - Stimulus: core 2, id 0, size_m1 0, issued twice.
//     - Response: rsp_valid on the cycle after each fire, rsp_mask=4'b0100 both times.
//  6) Reset mid-operation:
//     - Stimulus: 3 of 4 cores arrived at id 4, then assert reset.
//     - Response: busy=0 and rsp_valid=0 immediately (async). Post-reset, one core fires id 4 with size_m1 3: no release, mask=1 bit.

Source files
------------

// File: rtl/vx_gbar_unit.sv
// Cluster-level global barrier: round-robin accepts one core arrival per cycle,
// tracks per-barrier arrival masks and broadcasts a one-cycle release when complete.
module vx_gbar_unit #(
   parameter int NUM_CORES    = 4,
   parameter int NUM_BARRIERS = 16,
   parameter int BAR_ID_W     = $clog2(NUM_BARRIERS),
   parameter int CORE_W       = $clog2(NUM_CORES)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_CORES-1:0]          req_valid,
   input  logic [NUM_CORES*BAR_ID_W-1:0] req_id,
   input  logic [NUM_CORES*CORE_W-1:0]   req_size_m1,
   output logic [NUM_CORES-1:0]          req_ready,
   output logic                          rsp_valid,
   output logic [BAR_ID_W-1:0]           rsp_id,
   output logic [NUM_CORES-1:0]          rsp_mask,
   output logic                          busy
);

   localparam int CNT_W = CORE_W + 1;

   logic [CORE_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [NUM_CORES-1:0] mask_q [NUM_BARRIERS];
   logic [NUM_CORES-1:0] mask_d [NUM_BARRIERS];
   logic                 rsp_valid_q, rsp_valid_d;
   logic [BAR_ID_W-1:0]  rsp_id_q, rsp_id_d;
   logic [NUM_CORES-1:0] rsp_mask_q, rsp_mask_d;

   logic                 fire;
   logic [NUM_CORES-1:0] grant;
   logic [CORE_W-1:0]    grant_idx;
   logic [BAR_ID_W-1:0]  sel_id;
   logic [CORE_W-1:0]    sel_size;
   logic [NUM_CORES-1:0] cur_mask, new_mask;
   logic                 dup;
   logic [CNT_W-1:0]     arrived_cnt;
   logic                 release_now;
   logic                 any_mask;

   // Round-robin: scan cores starting at the pointer; the index wraps naturally
   // because NUM_CORES is a power of two.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      fire      = 1'b0;
      for (int k = 0; k < NUM_CORES; k++) begin
         if (!fire && req_valid[rr_ptr_q + CORE_W'(k)]) begin
            fire                            = 1'b1;
            grant_idx                       = rr_ptr_q + CORE_W'(k);
            grant[rr_ptr_q + CORE_W'(k)]    = 1'b1;
         end
      end
   end

   assign req_ready = grant;

   always_comb begin
      sel_id   = '0;
      sel_size = '0;
      for (int c = 0; c < NUM_CORES; c++) begin
         if (grant[c]) begin
            sel_id   = req_id[c*BAR_ID_W +: BAR_ID_W];
            sel_size = req_size_m1[c*CORE_W +: CORE_W];
         end
      end
   end

   assign cur_mask = mask_q[sel_id];
   assign new_mask = cur_mask | (NUM_CORES'(1) << grant_idx);
   assign dup      = cur_mask[grant_idx];

   // Count is one bit wider than size_m1 so a full house (size_m1+1 == NUM_CORES) cannot wrap.
   always_comb begin
      arrived_cnt = '0;
      for (int c = 0; c < NUM_CORES; c++) begin
         arrived_cnt = arrived_cnt + CNT_W'(new_mask[c]);
      end
   end

   assign release_now = fire && !dup && (arrived_cnt == (CNT_W'(sel_size) + CNT_W'(1)));

   always_comb begin
      mask_d      = mask_q;
      rr_ptr_d    = rr_ptr_q;
      rsp_valid_d = release_now;
      rsp_id_d    = release_now ? sel_id : '0;
      rsp_mask_d  = release_now ? new_mask : '0;
      if (fire) begin
         rr_ptr_d = grant_idx + CORE_W'(1);
         if (!dup) begin
            mask_d[sel_id] = release_now ? '0 : new_mask;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < NUM_BARRIERS; b++) begin
            mask_q[b] <= '0;
         end
         rr_ptr_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_mask_q  <= '0;
      end else begin
         mask_q      <= mask_d;
         rr_ptr_q    <= rr_ptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_mask_q  <= rsp_mask_d;
      end
   end

   always_comb begin
      any_mask = 1'b0;
      for (int b = 0; b < NUM_BARRIERS; b++) begin
         any_mask = any_mask | (|mask_q[b]);
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_mask  = rsp_mask_q;
   assign busy      = any_mask | rsp_valid_q;

endmodule

// File: tb/tb_vx_gbar_unit.sv
// Directed bench for vx_gbar_unit: a per-cycle vector table plus hand-written
// reset sequences; each row drives one cycle and checks that cycle's outputs.
module tb_vx_gbar_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [15:0] req_id = '0;
   logic [7:0]  req_size_m1 = '0;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [3:0]  rsp_id;
   logic [3:0]  rsp_mask;
   logic        busy;

   int total = 0;
   int bad   = 0;

   vx_gbar_unit #(.NUM_CORES(4), .NUM_BARRIERS(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_id      (req_id),
      .req_size_m1 (req_size_m1),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_mask    (rsp_mask),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Row n: inputs held during cycle n; rdy is this cycle's grant, rsp fields
   // reflect a completing fire in cycle n-1.
   typedef struct {
      logic [3:0]  v;
      logic [15:0] ids;
      logic [7:0]  szs;
      logic [3:0]  rdy;
      logic        rv;
      logic [3:0]  rid;
      logic [3:0]  rmask;
      logic        bsy;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic [3:0] v, logic [15:0] ids, logic [7:0] szs,
                               logic [3:0] rdy, logic rv, logic [3:0] rid,
                               logic [3:0] rmask, logic bsy);
      vec_t r;
      r.v = v; r.ids = ids; r.szs = szs; r.rdy = rdy;
      r.rv = rv; r.rid = rid; r.rmask = rmask; r.bsy = bsy;
      return r;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic apply(vec_t r, int n);
      @(posedge clk);
      #1;
      req_valid   = r.v;
      req_id      = r.ids;
      req_size_m1 = r.szs;
      @(negedge clk);
      chk($sformatf("row%0d ready", n), 32'(req_ready), 32'(r.rdy));
      chk($sformatf("row%0d rsp_valid", n), 32'(rsp_valid), 32'(r.rv));
      chk($sformatf("row%0d busy", n), 32'(busy), 32'(r.bsy));
      if (r.rv) begin
         chk($sformatf("row%0d rsp_id", n), 32'(rsp_id), 32'(r.rid));
         chk($sformatf("row%0d rsp_mask", n), 32'(rsp_mask), 32'(r.rmask));
      end
   endtask

   initial begin
      // single barrier: cores 0..3 arrive at id 5, size_m1 3
      tbl.push_back(mk(4'b0001, 16'h5555, 8'hFF, 4'b0001, 0, 0, 0,       0));
      tbl.push_back(mk(4'b0010, 16'h5555, 8'hFF, 4'b0010, 0, 0, 0,       1));
      tbl.push_back(mk(4'b0100, 16'h5555, 8'hFF, 4'b0100, 0, 0, 0,       1));
      tbl.push_back(mk(4'b1000, 16'h5555, 8'hFF, 4'b1000, 0, 0, 0,       1));
      tbl.push_back(mk(4'b0000, 16'h5555, 8'hFF, 4'b0000, 1, 5, 4'b1111, 1));
      tbl.push_back(mk(4'b0000, 16'h5555, 8'hFF, 4'b0000, 0, 0, 0,       0));
      // round-robin: all four valid on id 2, pointer 0
      tbl.push_back(mk(4'b1111, 16'h2222, 8'hFF, 4'b0001, 0, 0, 0,       0));
      tbl.push_back(mk(4'b1110, 16'h2222, 8'hFF, 4'b0010, 0, 0, 0,       1));
      tbl.push_back(mk(4'b1100, 16'h2222, 8'hFF, 4'b0100, 0, 0, 0,       1));
      tbl.push_back(mk(4'b1000, 16'h2222, 8'hFF, 4'b1000, 0, 0, 0,       1));
      tbl.push_back(mk(4'b0000, 16'h2222, 8'hFF, 4'b0000, 1, 2, 4'b1111, 1));
      // duplicate: core 1 twice on id 7 (size_m1 1), then core 0 completes
      tbl.push_back(mk(4'b0010, 16'h7777, 8'h55, 4'b0010, 0, 0, 0,       0));
      tbl.push_back(mk(4'b0010, 16'h7777, 8'h55, 4'b0010, 0, 0, 0,       1));
      tbl.push_back(mk(4'b0000, 16'h7777, 8'h55, 4'b0000, 0, 0, 0,       1));
      tbl.push_back(mk(4'b0001, 16'h7777, 8'h55, 4'b0001, 0, 0, 0,       1));
      tbl.push_back(mk(4'b0000, 16'h7777, 8'h55, 4'b0000, 1, 7, 4'b0011, 1));
      // interleaved: cores 0,1 on id 3 and cores 2,3 on id 9, pointer 1
      tbl.push_back(mk(4'b1111, 16'h9933, 8'h55, 4'b0010, 0, 0, 0,       0));
      tbl.push_back(mk(4'b1101, 16'h9933, 8'h55, 4'b0100, 0, 0, 0,       1));
      tbl.push_back(mk(4'b1001, 16'h9933, 8'h55, 4'b1000, 0, 0, 0,       1));
      tbl.push_back(mk(4'b0001, 16'h9933, 8'h55, 4'b0001, 1, 9, 4'b1100, 1));
      tbl.push_back(mk(4'b0000, 16'h9933, 8'h55, 4'b0000, 1, 3, 4'b0011, 1));
      tbl.push_back(mk(4'b0000, 16'h9933, 8'h55, 4'b0000, 0, 0, 0,       0));
      // self-release: core 2, id 0, size_m1 0, twice back to back
      tbl.push_back(mk(4'b0100, 16'h0000, 8'h00, 4'b0100, 0, 0, 0,       0));
      tbl.push_back(mk(4'b0100, 16'h0000, 8'h00, 4'b0100, 1, 0, 4'b0100, 1));
      tbl.push_back(mk(4'b0000, 16'h0000, 8'h00, 4'b0000, 1, 0, 4'b0100, 1));
      tbl.push_back(mk(4'b0000, 16'h0000, 8'h00, 4'b0000, 0, 0, 0,       0));

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset rsp_valid", 32'(rsp_valid), 0);
      chk("reset rsp_id", 32'(rsp_id), 0);
      chk("reset rsp_mask", 32'(rsp_mask), 0);
      chk("reset busy", 32'(busy), 0);
      chk("reset ready", 32'(req_ready), 0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], i);
      end

      // reset mid-operation: cores 0,1,2 at id 4 (size_m1 3); pointer is 3 here
      apply(mk(4'b0111, 16'h4444, 8'hFF, 4'b0001, 0, 0, 0, 0), 100);
      apply(mk(4'b0110, 16'h4444, 8'hFF, 4'b0010, 0, 0, 0, 1), 101);
      apply(mk(4'b0100, 16'h4444, 8'hFF, 4'b0100, 0, 0, 0, 1), 102);
      @(posedge clk);
      #1;
      req_valid = '0;
      #1;
      chk("pre-reset busy", 32'(busy), 1);
      reset = 1'b1;
      #1;
      chk("async reset busy", 32'(busy), 0);
      chk("async reset rsp_valid", 32'(rsp_valid), 0);
      @(negedge clk);
      reset = 1'b0;
      // one core at id 4 after reset: no release, a single bit keeps busy high
      apply(mk(4'b1000, 16'h4444, 8'hFF, 4'b1000, 0, 0, 0, 0), 103);
      apply(mk(4'b0000, 16'h4444, 8'hFF, 4'b0000, 0, 0, 0, 1), 104);
      apply(mk(4'b0000, 16'h4444, 8'hFF, 4'b0000, 0, 0, 0, 1), 105);

      // release in flight is dropped by reset
      apply(mk(4'b0010, 16'h1111, 8'h00, 4'b0010, 0, 0, 0, 1), 106);
      @(posedge clk);
      #1;
      req_valid = '0;
      chk("inflight rsp_valid", 32'(rsp_valid), 1);
      chk("inflight rsp_id", 32'(rsp_id), 1);
      reset = 1'b1;
      #1;
      chk("inflight dropped rsp_valid", 32'(rsp_valid), 0);
      chk("inflight dropped busy", 32'(busy), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("post-drop rsp_valid", 32'(rsp_valid), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
